// File: rtl/spmm_row_sched.sv
// spmm_row_sched: row-wise Gustavson scheduler for the CSR sparse matrix multiply.
// Walks each row of A and each nonzero in it, then each entry of the matching
// B row, and issues one (a_idx, b_idx, row, col) product request per accepted
// valid/ready handshake.
// Optional feature macro: SPMM_SCHED_STATS_EN adds prod_count_o, a count of
// accepted handshakes that clears on start.
module spmm_row_sched #(
  parameter int unsigned idx_width_param    = 4,
  parameter int unsigned max_elements_param = 16
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_ni,
  input  logic                                                    start_i,
  input  logic [idx_width_param-1:0]                              rows_A_i,
  input  logic [idx_width_param-1:0]                              rows_B_i,
  input  logic [0:max_elements_param-1][idx_width_param-1:0]      RPA_i,
  input  logic [0:max_elements_param-1][idx_width_param-1:0]      CIA_i,
  input  logic [0:max_elements_param-1][idx_width_param-1:0]      RPB_i,
  input  logic [0:max_elements_param-1][idx_width_param-1:0]      CIB_i,
  output logic                                                    issue_valid_o,
  input  logic                                                    issue_ready_i,
  output logic [idx_width_param-1:0]                              issue_a_idx_o,
  output logic [idx_width_param-1:0]                              issue_b_idx_o,
  output logic [idx_width_param-1:0]                              issue_row_o,
  output logic [idx_width_param-1:0]                              issue_col_o,
  output logic                                                    issue_last_o,
  output logic                                                    row_done_o,
  output logic [idx_width_param-1:0]                              row_done_idx_o,
  output logic                                                    busy_o,
  output logic                                                    done_o,
  output logic                                                    err_o
`ifdef SPMM_SCHED_STATS_EN
  ,
  output logic [2*idx_width_param-1:0]                            prod_count_o
`endif
);

  localparam int unsigned W  = idx_width_param;
  localparam int unsigned AW = (max_elements_param > 1) ? $clog2(max_elements_param) : 1;
  localparam int unsigned CW = 2 * idx_width_param;

  typedef logic [0:max_elements_param-1][W-1:0] csr_arr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_AFETCH,
    S_ISSUE,
    S_ROW_END,
    S_DONE
  } state_t;

  // Read one CSR array entry addressed by an index-width value.
  function automatic logic [W-1:0] rd(input csr_arr_t arr, input logic [W-1:0] idx);
    return arr[AW'(idx)];
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_rows_a, r_rows_b, r_row;
  logic [W-1:0]   r_a_ptr, r_a_end, r_b_ptr, r_b_end;
  logic           r_err;
  logic [W-1:0]   w_rows_a_nxt, w_rows_b_nxt, w_row_nxt;
  logic [W-1:0]   w_a_ptr_nxt, w_a_end_nxt, w_b_ptr_nxt, w_b_end_nxt;
  logic           w_err_nxt;

  logic [W-1:0]   w_a_inc, w_b_inc, w_row_inc;
  logic [W-1:0]   w_rpa_lo, w_rpa_hi, w_k, w_rpb_lo, w_rpb_hi;
  logic           w_fire;

  logic           w_valid_nxt, w_last_nxt, w_row_done_nxt;

  logic           r_issue_valid, r_issue_last, r_row_done, r_busy, r_done;
  logic [W-1:0]   r_issue_a, r_issue_b, r_issue_row, r_issue_col, r_row_done_idx;

  // Pointer increments and CSR lookups for the current state.
  assign w_a_inc   = r_a_ptr + W'(1);
  assign w_b_inc   = r_b_ptr + W'(1);
  assign w_row_inc = r_row + W'(1);
  assign w_rpa_lo  = rd(RPA_i, r_row);
  assign w_rpa_hi  = rd(RPA_i, w_row_inc);
  assign w_k       = rd(CIA_i, r_a_ptr);
  assign w_rpb_lo  = rd(RPB_i, w_k);
  assign w_rpb_hi  = rd(RPB_i, w_k + W'(1));
  assign w_fire    = (r_state == S_ISSUE) && issue_ready_i;

  // Next-state and datapath-register update logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_rows_a_nxt = r_rows_a;
    w_rows_b_nxt = r_rows_b;
    w_row_nxt    = r_row;
    w_a_ptr_nxt  = r_a_ptr;
    w_a_end_nxt  = r_a_end;
    w_b_ptr_nxt  = r_b_ptr;
    w_b_end_nxt  = r_b_end;
    w_err_nxt    = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_rows_a_nxt = rows_A_i;
          w_rows_b_nxt = rows_B_i;
          w_row_nxt    = '0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = (rows_A_i == '0) ? S_DONE : S_ROW;
        end
      end
      S_ROW: begin
        w_a_ptr_nxt = w_rpa_lo;
        w_a_end_nxt = w_rpa_hi;
        if (w_rpa_hi < w_rpa_lo) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_rpa_hi == w_rpa_lo) begin
          w_state_nxt = S_ROW_END;
        end else begin
          w_state_nxt = S_AFETCH;
        end
      end
      S_AFETCH: begin
        if ((w_k >= r_rows_b) || (w_rpb_hi < w_rpb_lo)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_b_ptr_nxt = w_rpb_lo;
          w_b_end_nxt = w_rpb_hi;
          if (w_rpb_hi == w_rpb_lo) begin
            w_a_ptr_nxt = w_a_inc;
            w_state_nxt = (w_a_inc == r_a_end) ? S_ROW_END : S_AFETCH;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_fire) begin
          w_b_ptr_nxt = w_b_inc;
          if (w_b_inc == r_b_end) begin
            w_a_ptr_nxt = w_a_inc;
            w_state_nxt = (w_a_inc == r_a_end) ? S_ROW_END : S_AFETCH;
          end
        end
      end
      S_ROW_END: begin
        if (w_row_inc == r_rows_a) begin
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = w_row_inc;
          w_state_nxt = S_ROW;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  assign w_valid_nxt    = (w_state_nxt == S_ISSUE);
  assign w_last_nxt     = w_valid_nxt && ((w_b_ptr_nxt + W'(1)) == w_b_end_nxt)
                                      && ((w_a_ptr_nxt + W'(1)) == w_a_end_nxt);
  assign w_row_done_nxt = (w_state_nxt == S_ROW_END);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Captured row counts, row index, A/B pointers and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rows_a <= '0;
      r_rows_b <= '0;
      r_row    <= '0;
      r_a_ptr  <= '0;
      r_a_end  <= '0;
      r_b_ptr  <= '0;
      r_b_end  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rows_a <= w_rows_a_nxt;
      r_rows_b <= w_rows_b_nxt;
      r_row    <= w_row_nxt;
      r_a_ptr  <= w_a_ptr_nxt;
      r_a_end  <= w_a_end_nxt;
      r_b_ptr  <= w_b_ptr_nxt;
      r_b_end  <= w_b_end_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Registered outputs; issue fields stay put during stalls since pointers hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue_valid  <= 1'b0;
      r_issue_a      <= '0;
      r_issue_b      <= '0;
      r_issue_row    <= '0;
      r_issue_col    <= '0;
      r_issue_last   <= 1'b0;
      r_row_done     <= 1'b0;
      r_row_done_idx <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_issue_valid  <= w_valid_nxt;
      r_issue_a      <= w_valid_nxt ? w_a_ptr_nxt : '0;
      r_issue_b      <= w_valid_nxt ? w_b_ptr_nxt : '0;
      r_issue_row    <= w_valid_nxt ? w_row_nxt : '0;
      r_issue_col    <= w_valid_nxt ? rd(CIB_i, w_b_ptr_nxt) : '0;
      r_issue_last   <= w_last_nxt;
      r_row_done     <= w_row_done_nxt;
      r_row_done_idx <= w_row_done_nxt ? w_row_nxt : '0;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_DONE);
    end
  end

  assign issue_valid_o  = r_issue_valid;
  assign issue_a_idx_o  = r_issue_a;
  assign issue_b_idx_o  = r_issue_b;
  assign issue_row_o    = r_issue_row;
  assign issue_col_o    = r_issue_col;
  assign issue_last_o   = r_issue_last;
  assign row_done_o     = r_row_done;
  assign row_done_idx_o = r_row_done_idx;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;

`ifdef SPMM_SCHED_STATS_EN
  logic [CW-1:0] r_prod_count;

  // Accepted-handshake counter; cleared on start, held after DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              r_prod_count <= '0;
    else if ((r_state == S_IDLE) && start_i)  r_prod_count <= '0;
    else if (w_fire)                          r_prod_count <= r_prod_count + CW'(1);
  end

  assign prod_count_o = r_prod_count;
`endif

endmodule

// File: tb/tb_spmm_row_sched.sv
// Scoreboard bench for spmm_row_sched: stimulus pushes expected products, row
// completions and run results into queues; a negedge monitor pops and compares.
module tb_spmm_row_sched;

  localparam int unsigned W = 4;
  localparam int unsigned N = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic         last;
  } prod_t;

  typedef struct {
    int   cyc;
    logic err;
    int   prods;
  } run_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] rows_a, rows_b;
  logic [0:N-1][W-1:0] rpa, cia, rpb, cib;
  logic rdy = 1'b1;
  logic issue_valid_o, issue_last_o, row_done_o, busy_o, done_o, err_o;
  logic [W-1:0] issue_a_idx_o, issue_b_idx_o, issue_row_o, issue_col_o, row_done_idx_o;
`ifdef SPMM_SCHED_STATS_EN
  logic [2*W-1:0] prod_count_o;
`endif

  spmm_row_sched #(.idx_width_param(W), .max_elements_param(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .rows_A_i(rows_a), .rows_B_i(rows_b),
    .RPA_i(rpa), .CIA_i(cia), .RPB_i(rpb), .CIB_i(cib),
    .issue_valid_o(issue_valid_o), .issue_ready_i(rdy),
    .issue_a_idx_o(issue_a_idx_o), .issue_b_idx_o(issue_b_idx_o),
    .issue_row_o(issue_row_o), .issue_col_o(issue_col_o),
    .issue_last_o(issue_last_o), .row_done_o(row_done_o),
    .row_done_idx_o(row_done_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef SPMM_SCHED_STATS_EN
    , .prod_count_o(prod_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Hand-computed products of the example matrices: a, b, row, col, last.
  int ex_tab [13][5] = '{
    '{0,3,0,0,0}, '{0,4,0,2,1},
    '{2,3,1,0,0}, '{2,4,1,2,1},
    '{3,0,2,0,0}, '{3,1,2,2,0}, '{3,2,2,3,0}, '{4,5,2,1,0}, '{4,6,2,2,0}, '{4,7,2,3,1},
    '{5,0,3,0,0}, '{5,1,3,2,0}, '{5,2,3,3,0}
  };
  int rpa_t [5] = '{0,1,3,5,7};
  int cia_t [7] = '{2,1,2,0,3,0,1};
  int rpb_t [5] = '{0,3,3,5,8};
  int cib_t [8] = '{0,2,3,0,2,1,2,3};

  prod_t exp_q [$];
  logic [W-1:0] row_q [$];
  run_t run_q [$];

  int n_vec = 0;
  int n_err = 0;
  int tmo_cnt = 0;
  logic bp_mode = 1'b0;
  logic fin = 1'b0;

  prod_t cur;
  assign cur = {issue_a_idx_o, issue_b_idx_o, issue_row_o, issue_col_o, issue_last_o};

  logic [63:0] all_outs;
`ifdef SPMM_SCHED_STATS_EN
  assign all_outs = 64'({cur, issue_valid_o, row_done_o, row_done_idx_o, busy_o, done_o, err_o, prod_count_o});
`else
  assign all_outs = 64'({cur, issue_valid_o, row_done_o, row_done_idx_o, busy_o, done_o, err_o});
`endif

  // Ready driver: either always ready, or refuse each new request for exactly one cycle.
  logic stalled = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!bp_mode) begin
      rdy = 1'b1; stalled = 1'b0;
    end else if (issue_valid_o && !stalled) begin
      rdy = 1'b0; stalled = 1'b1;
    end else begin
      rdy = 1'b1; stalled = 1'b0;
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor / scoreboard.
  prod_t held;
  logic  held_v = 1'b0;
  logic  active = 1'b0;
  logic  post_done = 1'b0;
  int    cyc = 0;
  int    tmo_seen = 0;
  always @(negedge clk) begin
    prod_t e;
    run_t  r;
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      chk("wait_timeout", 64'(1), 64'(0));
    end
    if (!rst_n) begin
      chk("reset_outputs_zero", all_outs, 64'(0));
      exp_q.delete(); row_q.delete(); run_q.delete();
      held_v = 1'b0; active = 1'b0; post_done = 1'b0;
    end else begin
      if (active) cyc++;
      if (post_done) begin
        chk("idle_after_done", 64'({busy_o, done_o}), 64'(0));
        post_done = 1'b0;
      end
      if (held_v) begin
        chk("stall_valid_hold", 64'(issue_valid_o), 64'(1));
        chk("stall_fields_hold", 64'(cur), 64'(held));
      end
      held_v = issue_valid_o && !rdy;
      held   = cur;
      if (issue_valid_o && rdy) begin
        if (exp_q.size() == 0) chk("unexpected_issue", 64'(cur), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("issue", 64'(cur), 64'(e));
        end
      end
      if (row_done_o) begin
        if (row_q.size() == 0) chk("unexpected_row_done", 64'(row_done_idx_o), 64'(0));
        else chk("row_done_idx", 64'(row_done_idx_o), 64'(row_q.pop_front()));
      end
      if (done_o) begin
        if (run_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          r = run_q.pop_front();
          chk("done_cycles", 64'(cyc), 64'(r.cyc));
          chk("err", 64'(err_o), 64'(r.err));
          chk("products_left", 64'(exp_q.size()), 64'(0));
          chk("rows_left", 64'(row_q.size()), 64'(0));
`ifdef SPMM_SCHED_STATS_EN
          chk("prod_count", 64'(prod_count_o), 64'(r.prods));
`endif
        end
        active = 1'b0;
        post_done = 1'b1;
      end
      if (start && !busy_o) begin
        active = 1'b1;
        cyc = 0;
      end
      if (fin) begin
        chk("final_products_left", 64'(exp_q.size()), 64'(0));
        chk("final_runs_left", 64'(run_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  task automatic load_example();
    rpa = '0; cia = '0; rpb = '0; cib = '0;
    for (int i = 0; i < 5; i++) rpa[i] = W'(rpa_t[i]);
    for (int i = 0; i < 7; i++) cia[i] = W'(cia_t[i]);
    for (int i = 0; i < 5; i++) rpb[i] = W'(rpb_t[i]);
    for (int i = 0; i < 8; i++) cib[i] = W'(cib_t[i]);
    rows_a = 4'd4;
    rows_b = 4'd4;
  endtask

  task automatic push_run(input int c, input logic e, input int p);
    run_t r;
    r.cyc = c; r.err = e; r.prods = p;
    run_q.push_back(r);
  endtask

  task automatic push_example(input int c);
    prod_t p;
    for (int i = 0; i < 13; i++) begin
      p.a = W'(ex_tab[i][0]); p.b = W'(ex_tab[i][1]); p.row = W'(ex_tab[i][2]);
      p.col = W'(ex_tab[i][3]); p.last = 1'(ex_tab[i][4]);
      exp_q.push_back(p);
    end
    for (int i = 0; i < 4; i++) row_q.push_back(W'(i));
    push_run(c, 1'b0, 13);
  endtask

  // Pulse start, optionally re-pulse it at a given busy cycle, and wait for done.
  task automatic go(input int extra_at);
    int n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (!done_o && n < 400) begin
      @(posedge clk); #1;
      n++;
      start = (n == extra_at);
    end
    if (!done_o) tmo_cnt++;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    load_example();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Example matrices, ready always high.
    push_example(29);
    go(0);

    // Same matrices, each request stalled one cycle.
    bp_mode = 1'b1;
    push_example(42);
    go(0);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Empty A.
    rows_a = 4'd0;
    push_run(1, 1'b0, 0);
    go(0);
    rows_a = 4'd4;

    // Column index of A out of range for B.
    cia[0] = 4'd4;
    push_run(3, 1'b1, 0);
    go(0);
    cia[0] = 4'd2;

    // Start re-pulsed while busy; also shows err cleared by the new start.
    push_example(29);
    go(5);

    // Reset during row 2 issue, then a full rerun.
    push_example(29);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(issue_valid_o && issue_row_o == 4'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) tmo_cnt++;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_example(29);
    go(0);

    fin = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_finish: summary not reached");
    $fatal(1);
  end

endmodule

// File: doc/spmm_row_sched.md
# spmm_row_sched

Row-wise Gustavson scheduler for the CSR sparse matrix multiply datapath. On `start_i` it walks every row of A and every nonzero of each row. For each nonzero it reads the matching row of B through the row pointers. It issues one (A index, B index, row, column) product request per cycle to the multiply-accumulate datapath over a valid/ready handshake. It sits between the top-level control inputs and the MAC/accumulator that builds NVC/CIC/RPC.

## Interface
- `idx_width_param`, default 4: width of every index, pointer, row and column value.
- `max_elements_param`, default 16: depth of the CSR arrays.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `rows_A_i`  in  idx_width_param  row count of A; captured at start.
- `rows_B_i`  in  idx_width_param  row count of B; captured at start.
- `RPA_i`, `CIA_i`, `RPB_i`, `CIB_i`  in  [0:max_elements_param-1][idx_width_param-1:0]  CSR pointers and columns; held stable while `busy_o`=1.
- `issue_valid_o`  out  1  product request valid.
- `issue_ready_i`  in  1  datapath accepts the request.
- `issue_a_idx_o`, `issue_b_idx_o`  out  idx_width_param  indices into NVA and NVB.
- `issue_row_o`, `issue_col_o`  out  idx_width_param  output row i and column CIB[b_idx].
- `issue_last_o`  out  1  final product of the current row.
- `row_done_o`  out  1  one-cycle pulse at the end of each row, including empty rows.
- `row_done_idx_o`  out  idx_width_param  row index for `row_done_o`.
- `busy_o`, `done_o`, `err_o`  out  1  busy; done pulse; sticky error.

## Operation
- States: IDLE, ROW, AFETCH, ISSUE, ROW_END, DONE.
- IDLE:
  - `start_i`=1 captures the row counts, sets r=0, and moves to ROW.
  - If `rows_A_i`==0, go straight to DONE.
  - Clears `err_o` on start.
- ROW: a_ptr=RPA[r], a_end=RPA[r+1].
  - If a_end<a_ptr: set err, go to DONE.
  - If a_ptr==a_end: go to ROW_END.
  - Otherwise go to AFETCH.
- AFETCH: k=CIA[a_ptr].
  - If k≥rows_B or RPB[k+1]<RPB[k]: set err, go to DONE.
  - Load b_ptr=RPB[k], b_end=RPB[k+1].
  - If the B row is empty: advance a_ptr, then go to AFETCH, or to ROW_END if a_ptr+1==a_end.
  - Otherwise go to ISSUE.
- ISSUE: drive a_ptr, b_ptr, r, CIB[b_ptr]. Each accepted handshake advances b_ptr.
  - After the last B entry: advance a_ptr, then go to AFETCH, or to ROW_END when the A row is exhausted.
- `issue_last_o`=1 when b_ptr+1==b_end and no later nonzero of A in this row yields a product. Lookahead is limited to the current a_ptr: `issue_last_o` is asserted only if a_ptr+1==a_end. If later A entries hit empty B rows, the row's last product carries `issue_last_o`=0; the datapath then uses `row_done_o`.
- ROW_END: pulse `row_done_o` with idx=r.
  - If r+1==rows_A: go to DONE.
  - Otherwise r++ and go to ROW.
- DONE: pulse `done_o` for one cycle, then go to IDLE.
- Pointer arithmetic is unsigned idx_width_param wide; no wrap is permitted. Supported nnz ≤ max_elements_param-1.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation immediately returns to IDLE with outputs 0; no flush pulse is produced.
- `busy_o`=1 in every state except IDLE. It rises the cycle after `start_i` is sampled.
- `start_i` is ignored while busy.
- Once asserted, `issue_valid_o` and all `issue_*` fields are held stable until `issue_ready_i`=1.
- Back-pressure stalls only the ISSUE state.
- ROW, AFETCH and ROW_END each take exactly 1 cycle. ISSUE takes 1 cycle per accepted product.
- Latency with ready held high: 2·rows_A + nnz(A) + products cycles, plus 1 DONE cycle.
- An error terminates within the same cycle's transition. `done_o` still pulses; `err_o` holds until the next start.

## Configuration
- `SPMM_SCHED_STATS_EN` defined:
  - Adds output `prod_count_o` (2·idx_width_param bits).
  - Counts accepted handshakes and clears on start.
  - Holds its value after DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Example matrices:
  - A: RPA={0,1,3,5,7}, CIA={2,1,2,0,3,0,1}, rows_A=4.
  - B: RPB={0,3,3,5,8}, CIB={0,2,3,0,2,1,2,3}, rows_B=4.
  - Products issued, listed as (a_idx, b_idx) per row:
    - Row 0: (0,3),(0,4).
    - Row 1: (2,3),(2,4). a1 hits empty B row 1.
    - Row 2: (3,0),(3,1),(3,2),(4,5),(4,6),(4,7).
    - Row 3: (5,0),(5,1),(5,2).
  - Required: 13 products; `done_o` 29 cycles after start; `err_o`=0.
  - Row 3: its final product (5,2) has `issue_last_o`=0; `row_done_o` pulses with idx 3.
  - With `SPMM_SCHED_STATS_EN`: `prod_count_o`=13.
- Same matrices with `issue_ready_i` low on alternate cycles -> identical request sequence, 13 extra stall cycles, fields stable during stalls.
- rows_A=0 -> DONE the cycle after start; `done_o` pulses, no issue, no `row_done_o`.
- CIA[0]=4 with rows_B=4 -> `err_o`=1 and `done_o` 3 cycles after start; no issue.
- `rst_ni` low during the row-2 ISSUE state -> all outputs 0 at once; a new start reruns the full 13-product sequence.
- `start_i` pulsed while busy -> ignored; sequence and cycle count unchanged.
